// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared states, operation codes and button priority for the calculator entry block
package calc_pkg;

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_EQ,
        S_REQ,
        S_RES,
        S_ERR
    } state_e;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;

    localparam int NUM_BTN = 5;

    typedef enum logic [2:0] {
        BTN_0     = 3'd0,
        BTN_1     = 3'd1,
        BTN_PLUS  = 3'd2,
        BTN_MINUS = 3'd3,
        BTN_EQUAL = 3'd4
    } btn_e;

    // Highest priority first.
    localparam btn_e BTN_PRIORITY [NUM_BTN] = '{BTN_EQUAL, BTN_PLUS, BTN_MINUS, BTN_1, BTN_0};

    // Keep only the highest-priority pulse; walking from lowest to highest lets the winner overwrite.
    function automatic logic [NUM_BTN-1:0] pick_pulse(input logic [NUM_BTN-1:0] pulses);
        logic [NUM_BTN-1:0] sel;
        sel = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pulses[BTN_PRIORITY[i]]) begin
                sel = '0;
                sel[BTN_PRIORITY[i]] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// rtl/calc_debounce.sv - two-flop synchronizer plus press/release debouncer emitting one pulse per press
module calc_debounce #(
    parameter int DEBOUNCE_CYCLES = 8000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          armed;
    logic [CW-1:0] count;

    // Armed: count high cycles toward a press. Disarmed: count low cycles toward re-arm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            armed  <= 1'b1;
            count  <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            pulse  <= 1'b0;
            if (sync_2 == armed) begin
                if (count == LAST) begin
                    count <= '0;
                    armed <= ~armed;
                    pulse <= armed;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - binary operand/operator entry FSM with ALU request handshake
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_0,
    input  logic       btn_1,
    input  logic       btn_plus,
    input  logic       btn_minus,
    input  logic       btn_equal,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [1:0] op_code,
    output logic       alu_req,
    input  logic       alu_ack,
    input  logic [3:0] alu_result,
    input  logic       alu_err,
    output logic [3:0] result,
    output logic [7:0] digit_en,
    output logic       err,
    output logic       busy
);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] pulse_vec;
    logic [NUM_BTN-1:0] sel;

    assign raw_vec = {btn_equal, btn_minus, btn_plus, btn_1, btn_0};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        calc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (raw_vec[i]),
            .pulse(pulse_vec[i])
        );
    end

    state_e     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [3:0] op_a_n, op_b_n, result_n;
    logic [1:0] op_code_n;
    logic [7:0] digit_mask, digit_mask_n;
    logic       digit_hit, digit_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_A;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= OP_NONE;
            result     <= '0;
            digit_mask <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            op_a       <= op_a_n;
            op_b       <= op_b_n;
            op_code    <= op_code_n;
            result     <= result_n;
            digit_mask <= digit_mask_n;
        end
    end

    // MSB-first entry: bit index 3-cnt is ~cnt for a 2-bit counter.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        op_a_n       = op_a;
        op_b_n       = op_b;
        op_code_n    = op_code;
        result_n     = result;
        digit_mask_n = digit_mask;
        sel          = pick_pulse(pulse_vec);
        digit_hit    = sel[BTN_0] | sel[BTN_1];
        digit_val    = sel[BTN_1];

        case (state)
            S_A: begin
                if (digit_hit) begin
                    op_a_n[~cnt]                = digit_val;
                    digit_mask_n[{1'b1, ~cnt}] = 1'b1;
                    cnt_n                       = cnt + 2'd1;
                    if (cnt == 2'd3) state_n = S_OP;
                end
            end
            S_OP: begin
                if (sel[BTN_PLUS]) begin
                    op_code_n = OP_ADD;
                    state_n   = S_B;
                end else if (sel[BTN_MINUS]) begin
                    op_code_n = OP_SUB;
                    state_n   = S_B;
                end
            end
            S_B: begin
                if (digit_hit) begin
                    op_b_n[~cnt]                = digit_val;
                    digit_mask_n[{1'b0, ~cnt}] = 1'b1;
                    cnt_n                       = cnt + 2'd1;
                    if (cnt == 2'd3) state_n = S_EQ;
                end
            end
            S_EQ: begin
                if (sel[BTN_EQUAL]) state_n = S_REQ;
            end
            S_REQ: begin
                if (alu_ack) begin
                    op_code_n = OP_NONE;
                    if (alu_err) begin
                        state_n = S_ERR;
                    end else begin
                        result_n = alu_result;
                        state_n  = S_RES;
                    end
                end
            end
            S_RES: begin
                if (digit_hit) begin
                    op_a_n       = {digit_val, 3'b000};
                    op_b_n       = '0;
                    digit_mask_n = 8'h80;
                    result_n     = '0;
                    cnt_n        = 2'd1;
                    state_n      = S_A;
                end
            end
            S_ERR: begin
                if (sel[BTN_EQUAL]) begin
                    op_a_n       = '0;
                    op_b_n       = '0;
                    op_code_n    = OP_NONE;
                    result_n     = '0;
                    digit_mask_n = '0;
                    cnt_n        = '0;
                    state_n      = S_A;
                end
            end
            default: state_n = S_A;
        endcase
    end

    assign alu_req  = (state == S_REQ);
    assign busy     = (state == S_REQ);
    assign err      = (state == S_ERR);
    assign digit_en = err ? 8'hFF : digit_mask;

endmodule
